// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and types for the memory-mapped GPIO controller.
//   - GPIO_BASE_DEFAULT : default byte address of register offset 0
//   - OFF_*             : byte offsets of the five registers in the window
//   - reg_sel_t         : 3-bit register-select encoding produced by the decoder
package gpio_pkg;

  localparam logic [31:0] GPIO_BASE_DEFAULT = 32'h0000_ABCD;

  localparam logic [31:0] OFF_DOUT = 32'h0000_0000;
  localparam logic [31:0] OFF_DIR  = 32'h0000_0004;
  localparam logic [31:0] OFF_DIN  = 32'h0000_0008;
  localparam logic [31:0] OFF_IE   = 32'h0000_000C;
  localparam logic [31:0] OFF_IS   = 32'h0000_0010;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_DOUT = 3'd1,
    SEL_DIR  = 3'd2,
    SEL_DIN  = 3'd3,
    SEL_IE   = 3'd4,
    SEL_IS   = 3'd5
  } reg_sel_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: brings asynchronous pin inputs into the clk domain and
// flags rising edges.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   pins  : raw asynchronous pin levels
//   din   : synchronised pin levels (second synchroniser stage)
//   rise  : one-cycle pulse per pin on a 0->1 transition of din
module gpio_sync_edge #(
  parameter int N_PINS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_PINS-1:0] pins,
  output logic [N_PINS-1:0] din,
  output logic [N_PINS-1:0] rise
);

  logic [N_PINS-1:0] sync1;
  logic [N_PINS-1:0] sync2;
  logic [N_PINS-1:0] prev;

  // NOTE: non-blocking assignments so every stage samples the value the
  // previous stage held before this edge; blocking here would collapse the
  // chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign din  = sync2;
  assign rise = sync2 & ~prev;

endmodule

// File: rtl/gpio_controller.sv
// gpio_controller: memory-mapped GPIO peripheral on the data-memory bus.
//   clk, rst_n : system clock / asynchronous active-low reset
//   MemW, MemR : store / load strobes from the core
//   ALU_out    : effective byte address, WD: store data
//   RD         : registered load data, valid when rd_valid is high
//   hit        : combinational address match (masks data-memory writes)
//   gpio_in    : asynchronous pin inputs
//   gpio_out   : output register, gpio_oe: per-pin drive enable
//   irq        : level interrupt, |(IS & IE) registered
// Registers (offset from GPIO_BASE): 0x0 DOUT, 0x4 DIR, 0x8 DIN (RO),
// 0xC IE, 0x10 IS (write-1-to-clear).
module gpio_controller
  import gpio_pkg::*;
#(
  parameter logic [31:0] GPIO_BASE = GPIO_BASE_DEFAULT,
  parameter int          N_PINS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemW,
  input  logic              MemR,
  input  logic [31:0]       ALU_out,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              rd_valid,
  output logic              hit,
  input  logic [N_PINS-1:0] gpio_in,
  output logic [N_PINS-1:0] gpio_out,
  output logic [N_PINS-1:0] gpio_oe,
  output logic              irq
);

  logic [N_PINS-1:0] dout_q;
  logic [N_PINS-1:0] dir_q;
  logic [N_PINS-1:0] ie_q;
  logic [N_PINS-1:0] is_q;
  logic [N_PINS-1:0] din;
  logic [N_PINS-1:0] rise;
  logic [N_PINS-1:0] wdata;
  logic [N_PINS-1:0] w1c_mask;
  logic [31:0]       offset;
  logic [31:0]       rd_word;
  reg_sel_t          sel;
  logic              wr;
  logic              unused_wd;

  gpio_sync_edge #(.N_PINS(N_PINS)) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (gpio_in),
    .din   (din),
    .rise  (rise)
  );

  // Wrapping 32-bit subtraction: addresses below the base land far outside
  // the window rather than aliasing onto it.
  assign offset = ALU_out - GPIO_BASE;

  // NOTE: every output of a combinational block gets a default before the
  // branches, otherwise an uncovered path would infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if      (offset == OFF_DOUT) sel = SEL_DOUT;
    else if (offset == OFF_DIR)  sel = SEL_DIR;
    else if (offset == OFF_DIN)  sel = SEL_DIN;
    else if (offset == OFF_IE)   sel = SEL_IE;
    else if (offset == OFF_IS)   sel = SEL_IS;
  end

  assign hit   = (sel != SEL_NONE);
  assign wr    = MemW & hit;
  assign wdata = WD[N_PINS-1:0];

  // Upper store-data bits carry no meaning for an N_PINS-wide register.
  assign unused_wd = ^WD;

  assign w1c_mask = (wr && sel == SEL_IS) ? wdata : '0;

  // Read mux over current register values, so a simultaneous write and
  // read returns the pre-write contents. Narrow registers zero-extend.
  always_comb begin
    rd_word = '0;
    unique case (sel)
      SEL_DOUT: rd_word[N_PINS-1:0] = dout_q;
      SEL_DIR:  rd_word[N_PINS-1:0] = dir_q;
      SEL_DIN:  rd_word[N_PINS-1:0] = din;
      SEL_IE:   rd_word[N_PINS-1:0] = ie_q;
      SEL_IS:   rd_word[N_PINS-1:0] = is_q;
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      dir_q    <= '0;
      ie_q     <= '0;
      is_q     <= '0;
      irq      <= 1'b0;
      RD       <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr && sel == SEL_DOUT) dout_q <= wdata;
      if (wr && sel == SEL_DIR)  dir_q  <= wdata;
      if (wr && sel == SEL_IE)   ie_q   <= wdata;

      // Clear first, then OR in new enabled edges: an edge arriving in the
      // same cycle as its clear keeps the bit set, so no event is lost.
      is_q <= (is_q & ~w1c_mask) | (rise & ie_q);

      irq <= |(is_q & ie_q);

      rd_valid <= MemR & hit;
      if (MemR && hit) RD <= rd_word;
    end
  end

  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_gpio_controller.sv
// tb_gpio_controller: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the GPIO register file.
module tb_gpio_controller;

  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h0000_ABCD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          MemW = 1'b0;
  logic          MemR = 1'b0;
  logic [31:0]   ALU_out = '0;
  logic [31:0]   WD = '0;
  logic [31:0]   RD;
  logic          rd_valid;
  logic          hit;
  logic [N-1:0]  gpio_in = '0;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_oe;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_controller #(.GPIO_BASE(BASE), .N_PINS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemW     (MemW),
    .MemR     (MemR),
    .ALU_out  (ALU_out),
    .WD       (WD),
    .RD       (RD),
    .rd_valid (rd_valid),
    .hit      (hit),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural register contents plus the history of pin values applied
  // since reset; DIN is simply the pin value from two cycles ago.
  logic [N-1:0] m_dout, m_dir, m_ie, m_is;
  logic         m_irq, m_valid;
  logic [31:0]  m_rd;
  logic [N-1:0] pin_q[$];

  function automatic logic [N-1:0] pins_ago(input int d);
    int idx;
    idx = pin_q.size() - 1 - d;
    return (idx < 0) ? '0 : pin_q[idx];
  endfunction

  function automatic bit in_window(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (off == 0) || (off == 4) || (off == 8) || (off == 12) || (off == 16);
  endfunction

  task automatic model_reset();
    m_dout = '0; m_dir = '0; m_ie = '0; m_is = '0;
    m_irq = 1'b0; m_valid = 1'b0; m_rd = '0;
    pin_q.delete();
  endtask

  task automatic model_edge(input bit we, input bit re, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [N-1:0] pins);
    logic [31:0]  off;
    logic [N-1:0] din_v, edges, clr, val;
    bit           h;
    pin_q.push_back(pins);
    din_v = pins_ago(2);
    edges = din_v & ~pins_ago(3);
    off   = addr - BASE;
    h     = in_window(addr);
    val   = '0;
    case (off)
      32'd0:  val = m_dout;
      32'd4:  val = m_dir;
      32'd8:  val = din_v;
      32'd12: val = m_ie;
      32'd16: val = m_is;
      default: val = '0;
    endcase
    m_valid = re && h;
    if (re && h) m_rd = {{(32-N){1'b0}}, val};
    clr   = (we && h && off == 32'd16) ? wd[N-1:0] : '0;
    m_irq = |(m_is & m_ie);
    m_is  = (m_is & ~clr) | (edges & m_ie);
    if (we && h && off == 32'd0)  m_dout = wd[N-1:0];
    if (we && h && off == 32'd4)  m_dir  = wd[N-1:0];
    if (we && h && off == 32'd12) m_ie   = wd[N-1:0];
  endtask

  // One bus cycle: drive at the falling edge, check hit combinationally,
  // then check all registered outputs at the following falling edge.
  task automatic step(input bit we, input bit re, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [N-1:0] pins);
    MemW = we; MemR = re; ALU_out = addr; WD = wd; gpio_in = pins;
    #1;
    check("hit", {31'd0, hit}, {31'd0, in_window(addr)});
    model_edge(we, re, addr, wd, pins);
    @(negedge clk);
    check("gpio_out", {16'd0, gpio_out}, {16'd0, m_dout});
    check("gpio_oe",  {16'd0, gpio_oe},  {16'd0, m_dir});
    check("irq",      {31'd0, irq},      {31'd0, m_irq});
    check("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
    check("RD",       RD,                m_rd);
  endtask

  task automatic idle(input logic [N-1:0] pins);
    step(1'b0, 1'b0, BASE + 32'h100, 32'd0, pins);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; MemW = 1'b0; MemR = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [N-1:0] pins;
    int r;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset values: read every register, one idle cycle between reads.
    check("rst_oe", {16'd0, gpio_oe}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, BASE + 32'(4 * i), 32'd0, '0);
      check("rst_rd", RD, 32'd0);
      check("rst_valid", {31'd0, rd_valid}, 32'd1);
      idle('0);
    end

    // 2. Output write, and a near-miss address that must not hit.
    step(1'b1, 1'b0, BASE, 32'hFFFF_A5A5, '0);
    check("dout_wr", {16'd0, gpio_out}, 32'h0000_A5A5);
    step(1'b1, 1'b0, 32'h0000_ABCC, 32'h0000_1234, '0);
    check("dout_miss", {16'd0, gpio_out}, 32'h0000_A5A5);

    // 3. Input latency: DIN shows the new pins from the third read.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, BASE + 32'h8, 32'd0, 16'h0003);
      check("din_lat", RD, (i < 2) ? 32'd0 : 32'd3);
    end
    step(1'b0, 1'b0, BASE, 32'd0, 16'h0000);
    for (int i = 0; i < 3; i++) idle('0);

    // 4. IE on pin 0 only; both pins rise, irq appears four clocks later.
    step(1'b1, 1'b0, BASE + 32'hC, 32'h0000_0001, '0);
    for (int i = 0; i < 4; i++) begin
      idle(16'h0003);
      check("irq_lat", {31'd0, irq}, (i == 3) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b1, BASE + 32'h10, 32'd0, 16'h0003);
    check("is_pin0", RD, 32'd1);

    // 5. Clear colliding with a fresh pin-0 edge: the edge wins.
    for (int i = 0; i < 4; i++) idle(16'h0002);
    idle(16'h0003);
    idle(16'h0003);
    step(1'b1, 1'b0, BASE + 32'h10, 32'h0000_0001, 16'h0003);
    step(1'b0, 1'b1, BASE + 32'h10, 32'd0, 16'h0003);
    check("w1c_collide", RD, 32'd1);
    check("irq_collide", {31'd0, irq}, 32'd1);
    step(1'b1, 1'b0, BASE + 32'h10, 32'h0000_0001, 16'h0003);
    check("irq_hold", {31'd0, irq}, 32'd1);
    step(1'b0, 1'b1, BASE + 32'h10, 32'd0, 16'h0003);
    check("w1c_clear", RD, 32'd0);
    check("irq_clear", {31'd0, irq}, 32'd0);

    // 6. Reset asserted between a read request and its completion edge.
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0000_00FF, 16'h0000);
    for (int i = 0; i < 3; i++) idle('0);
    MemW = 1'b0; MemR = 1'b1; ALU_out = BASE;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out", {16'd0, gpio_out}, 32'd0);
    check("ar_oe", {16'd0, gpio_oe}, 32'd0);
    check("ar_irq", {31'd0, irq}, 32'd0);
    check("ar_rd", RD, 32'd0);
    @(posedge clk);
    #1;
    check("ar_valid", {31'd0, rd_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    MemR = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, BASE + 32'(4 * i), 32'd0, '0);
      check("ar_reg", RD, 32'd0);
    end

    // Randomized traffic against the model.
    do_reset();
    pins = '0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)       addr = BASE + 32'(4 * r);
      else if (r == 5) addr = BASE + 32'($urandom_range(0, 24));
      else if (r == 6) addr = BASE - 32'd4;
      else if (r == 7) addr = $urandom;
      else             addr = BASE + 32'h10;
      if ($urandom_range(0, 3) == 0) pins = N'($urandom);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, addr, $urandom, pins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
